scan_sequencer: RTL and testbench

Upstream select generator for the 3-to-8 one-hot decoder. It produces a registered 3-bit select that steps through positions 0..7 at a programmable rate. Supported patterns are up, down, ping-pong and hold, plus a synchronous load. Its `sel` output drives the decoder directly to scan 8 LEDs, digit enables or keypad rows.

---
 rtl/scan_pkg.sv | 20 ++
 rtl/tick_gen.sv | 34 +++
 rtl/scan_sequencer.sv | 145 ++++++++++++++
 tb/tb_scan_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared constants and types for the LED/digit scan sequencer.
package scan_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DN   = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [2:0] SEL_MAX = 3'd7;

  typedef enum logic {
    ST_UP = 1'b0,
    ST_DN = 1'b1
  } pp_state_t;

  function automatic logic at_end(input logic [2:0] pos);
    return (pos == 3'd0) || (pos == SEL_MAX);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: raises step for one cycle every PRESCALE enabled cycles; clr restarts the count.
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_cnt_r;

  assign step = en && (pre_cnt_r == LAST);

  // Prescale counter: wraps on the step cycle, holds while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_r <= CW'(0);
    end else if (clr) begin
      pre_cnt_r <= CW'(0);
    end else if (step) begin
      pre_cnt_r <= CW'(0);
    end else if (en) begin
      pre_cnt_r <= pre_cnt_r + CW'(1);
    end else begin
      pre_cnt_r <= pre_cnt_r;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Registered 3-bit scan select generator (up/down/ping-pong/hold + load).
// Optional decoder blanking strobe enabled by defining SCAN_BLANK_EN.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int SIZE_SEL = 3,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic                load,
  input  logic [SIZE_SEL-1:0] load_val,
  output logic [SIZE_SEL-1:0] sel,
  output logic                tick,
  output logic                wrap,
  output logic                blank
);

  logic                step_s;
  logic [SIZE_SEL-1:0] sel_r;
  logic [SIZE_SEL-1:0] sel_nxt_s;
  logic [SIZE_SEL-1:0] pp_sel_s;
  logic                pp_up_s;
  logic                tick_r;
  logic                wrap_r;
  logic                tick_nxt_s;
  logic                wrap_nxt_s;
  pp_state_t           st_r;
  pp_state_t           st_nxt_s;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (load),
    .step (step_s)
  );

  // An UP state parked at 7 or a DN state parked at 0 turns around instead of wrapping.
  assign pp_up_s  = ((st_r == ST_UP) && (sel_r != SEL_MAX)) ||
                    ((st_r == ST_DN) && (sel_r == 3'd0));
  assign pp_sel_s = pp_up_s ? (sel_r + 3'd1) : (sel_r - 3'd1);

  // Ping-pong state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r <= ST_UP;
    end else begin
      st_r <= st_nxt_s;
    end
  end

  // Ping-pong next state: loads and ping-pong steps only; other modes keep it.
  always_comb begin
    st_nxt_s = st_r;
    if (load) begin
      st_nxt_s = (load_val == SEL_MAX) ? ST_DN : ST_UP;
    end else if (step_s && (mode == MODE_PP)) begin
      if (pp_sel_s == SEL_MAX) begin
        st_nxt_s = ST_DN;
      end else if (pp_sel_s == 3'd0) begin
        st_nxt_s = ST_UP;
      end else begin
        st_nxt_s = pp_up_s ? ST_UP : ST_DN;
      end
    end else begin
      st_nxt_s = st_r;
    end
  end

  // Next position and pulse values.
  always_comb begin
    sel_nxt_s  = sel_r;
    tick_nxt_s = 1'b0;
    wrap_nxt_s = 1'b0;
    if (load) begin
      sel_nxt_s = load_val;
    end else if (step_s) begin
      case (mode)
        MODE_UP: begin
          sel_nxt_s  = sel_r + 3'd1;
          tick_nxt_s = 1'b1;
          wrap_nxt_s = (sel_r == SEL_MAX);
        end
        MODE_DN: begin
          sel_nxt_s  = sel_r - 3'd1;
          tick_nxt_s = 1'b1;
          wrap_nxt_s = (sel_r == 3'd0);
        end
        MODE_PP: begin
          sel_nxt_s  = pp_sel_s;
          tick_nxt_s = 1'b1;
          wrap_nxt_s = at_end(pp_sel_s);
        end
        MODE_HOLD: begin
          sel_nxt_s = sel_r;
        end
        default: begin
          sel_nxt_s = sel_r;
        end
      endcase
    end else begin
      sel_nxt_s = sel_r;
    end
  end

  // Position and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r  <= 3'd0;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      sel_r  <= sel_nxt_s;
      tick_r <= tick_nxt_s;
      wrap_r <= wrap_nxt_s;
    end
  end

  assign sel  = sel_r;
  assign tick = tick_r;
  assign wrap = wrap_r;

`ifdef SCAN_BLANK_EN
  logic blank_r;

  // Blank on every position update, including loads of the current value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_r <= 1'b0;
    end else begin
      blank_r <= tick_nxt_s | load;
    end
  end

  assign blank = blank_r;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed self-checking bench for scan_sequencer (PRESCALE=4).
module tb_scan_sequencer;

  localparam logic [1:0] M_UP   = 2'b00;
  localparam logic [1:0] M_DN   = 2'b01;
  localparam logic [1:0] M_PP   = 2'b10;
  localparam logic [1:0] M_HOLD = 2'b11;
`ifdef SCAN_BLANK_EN
  localparam logic BLK = 1'b1;
`else
  localparam logic BLK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] sel;
  logic       tick;
  logic       wrap;
  logic       blank;

  int         n_checks;
  int         n_errors;
  logic [2:0] track_sel;

  scan_sequencer #(
    .SIZE_SEL(3),
    .PRESCALE(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .load    (load),
    .load_val(load_val),
    .sel     (sel),
    .tick    (tick),
    .wrap    (wrap),
    .blank   (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // n cycles with no step expected: sel frozen, all pulses low
  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      check("quiet_sel", 32'(sel), 32'(track_sel));
      check("quiet_tick", 32'(tick), 32'd0);
      check("quiet_wrap", 32'(wrap), 32'd0);
      check("quiet_blank", 32'(blank), 32'd0);
    end
  endtask

  task automatic step_chk(input logic [2:0] es, input logic ew);
    cycle();
    check("step_sel", 32'(sel), 32'(es));
    check("step_tick", 32'(tick), 32'd1);
    check("step_wrap", 32'(wrap), 32'(ew));
    check("step_blank", 32'(blank), 32'(BLK));
    track_sel = es;
  endtask

  // assumes prescaler at 0: three idle cycles then the step
  task automatic run_step(input logic [2:0] es, input logic ew);
    quiet(3);
    step_chk(es, ew);
  endtask

  task automatic load_chk(input logic [2:0] v);
    load     = 1'b1;
    load_val = v;
    cycle();
    load = 1'b0;
    check("load_sel", 32'(sel), 32'(v));
    check("load_tick", 32'(tick), 32'd0);
    check("load_wrap", 32'(wrap), 32'd0);
    check("load_blank", 32'(blank), 32'(BLK));
    track_sel = v;
  endtask

  logic [2:0] pp_seq [16];
  logic       pp_wr  [16];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    track_sel = 3'd0;
    rst_n     = 1'b0;
    en        = 1'b0;
    mode      = M_UP;
    load      = 1'b0;
    load_val  = 3'd0;
    pp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
               3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
    pp_wr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // reset state
    cycle();
    cycle();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_blank", 32'(blank), 32'd0);

    // up mode, 40 cycles: 1..7,0,1,2 with wrap only on 7->0
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      run_step(3'(i % 8), (i % 8) == 0);
    end

    // down mode from 0
    load_chk(3'd0);
    mode = M_DN;
    run_step(3'd7, 1'b1);
    run_step(3'd6, 1'b0);
    run_step(3'd5, 1'b0);

    // ping-pong from 0, no repeats at the turns
    load_chk(3'd0);
    mode = M_PP;
    for (int i = 0; i < 16; i++) begin
      run_step(pp_seq[i], pp_wr[i]);
    end

    // load coincident with a step condition
    mode = M_UP;
    quiet(3);
    load_chk(3'd5);
    run_step(3'd6, 1'b0);

    // enable gap with pre_cnt=2
    quiet(2);
    en = 1'b0;
    quiet(10);
    en = 1'b1;
    quiet(1);
    step_chk(3'd7, 1'b0);

    // async reset mid-count
    quiet(2);
    rst_n = 1'b0;
    #2;
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_wrap", 32'(wrap), 32'd0);
    check("arst_blank", 32'(blank), 32'd0);
    track_sel = 3'd0;
    cycle();
    rst_n = 1'b1;
    run_step(3'd1, 1'b0);

    // hold: prescaler runs, nothing steps
    mode = M_HOLD;
    quiet(8);
    load_chk(3'd1);

    // load 7 puts ping-pong into DN
    load_chk(3'd7);
    mode = M_PP;
    run_step(3'd6, 1'b0);
    run_step(3'd5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
